// File: rtl/keypad_entry_scanner.sv
// Open-drain matrix keypad scanner: column-by-column frame capture, frame-level
// debounce with release arming, and multi-digit entry packing with a KeyRd handshake.
module keypad_entry_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DIGIT_W  = 4,
  parameter int DIGITS   = 4,
  parameter int SETTLE   = 1,
  parameter int DEBOUNCE = 2
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [ROWS-1:0]               RowIn,
  output logic [COLS-1:0]               ColOut,
  input  logic                          KeyRd,
  output logic [DIGIT_W-1:0]            key_code,
  output logic                          key_strobe,
  output logic [DIGITS*DIGIT_W-1:0]     entry,
  output logic [$clog2(DIGITS+1)-1:0]   digit_count,
  output logic                          data_ready,
  output logic                          multi_key,
  output logic                          overflow
);

  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int NB = ROWS * COLS;
  localparam int EW = DIGITS * DIGIT_W;
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [3:0] DBW = 4'(DEBOUNCE);

  localparam logic [0:0] SCAN = 1'b0;
  localparam logic [0:0] EVAL = 1'b1;

  localparam logic [1:0] CLS_NONE   = 2'd0;
  localparam logic [1:0] CLS_SINGLE = 2'd1;
  localparam logic [1:0] CLS_MULTI  = 2'd2;

  logic [0:0]         state;
  logic [CW-1:0]      col;
  logic [SW-1:0]      slot_cnt;
  logic [NB-1:0]      frame;
  logic [3:0]         stable_cnt;
  logic               armed;
  logic [1:0]         prev_cls;
  logic [DIGIT_W-1:0] prev_code;

  logic               any_key, many_keys;
  logic [DIGIT_W-1:0] code;
  logic [1:0]         cls;
  logic               same;
  logic [3:0]         next_cnt;
  logic               accept;
  logic               ack;
  logic [EW-1:0]      base_entry, fresh_entry;
  logic [NW-1:0]      base_count, next_count;

  // Frame bit c*ROWS+r maps to key code r*COLS+c.
  always_comb begin
    any_key   = 1'b0;
    many_keys = 1'b0;
    code      = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (frame[c*ROWS + r]) begin
          many_keys = many_keys | any_key;
          any_key   = 1'b1;
          code      = DIGIT_W'(r*COLS + c);
        end
      end
    end
  end

  always_comb begin
    cls = many_keys ? CLS_MULTI : (any_key ? CLS_SINGLE : CLS_NONE);
    same = (cls == prev_cls) && ((cls != CLS_SINGLE) || (code == prev_code));
    if (!same)
      next_cnt = 4'd1;
    else if (stable_cnt >= DBW)
      next_cnt = DBW;
    else
      next_cnt = stable_cnt + 4'd1;
    accept = (state == EVAL) && (cls == CLS_SINGLE) && armed && (next_cnt == DBW);
    ack    = data_ready && KeyRd;
    // A simultaneous acknowledge empties the entry first, so the key starts a new one.
    base_entry  = ack ? '0 : entry;
    base_count  = ack ? '0 : digit_count;
    fresh_entry = (base_entry << DIGIT_W) | EW'(code);
    next_count  = base_count + NW'(1);
  end

  for (genvar i = 0; i < COLS; i++) begin : g_col
    assign ColOut[i] = (state == SCAN && col == CW'(i)) ? 1'b0 : 1'bz;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= SCAN;
      col         <= '0;
      slot_cnt    <= '0;
      frame       <= '0;
      stable_cnt  <= '0;
      armed       <= 1'b0;
      prev_cls    <= CLS_NONE;
      prev_code   <= '0;
      key_code    <= '0;
      key_strobe  <= 1'b0;
      entry       <= '0;
      digit_count <= '0;
      data_ready  <= 1'b0;
      multi_key   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (ack) begin
        data_ready  <= 1'b0;
        digit_count <= '0;
        entry       <= '0;
        overflow    <= 1'b0;
      end
      if (state == SCAN) begin
        if (slot_cnt == SW'(SETTLE)) begin
          slot_cnt <= '0;
          for (int unsigned c = 0; c < COLS; c++) begin
            if (col == CW'(c))
              frame[c*ROWS +: ROWS] <= ~RowIn;
          end
          if (col == CW'(COLS - 1))
            state <= EVAL;
          else
            col <= col + CW'(1);
        end else begin
          slot_cnt <= slot_cnt + SW'(1);
        end
      end else begin
        state      <= SCAN;
        col        <= '0;
        multi_key  <= (cls == CLS_MULTI);
        prev_cls   <= cls;
        prev_code  <= code;
        stable_cnt <= next_cnt;
        if (accept) begin
          armed      <= 1'b0;
          key_code   <= code;
          key_strobe <= 1'b1;
          if (data_ready && !ack) begin
            overflow <= 1'b1;
          end else begin
            entry       <= fresh_entry;
            digit_count <= next_count;
            data_ready  <= (next_count == NW'(DIGITS));
          end
        end else if (cls == CLS_NONE && next_cnt == DBW) begin
          armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner: default 4x4 instance plus a 2x3, SETTLE=2 instance.
module tb_keypad_entry_scanner;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Reset  = 1'b1;
  logic Reset2 = 1'b1;
  logic KeyRd  = 1'b0;
  logic KeyRd2 = 1'b0;

  // default instance
  logic [15:0] keys1 = '0;
  logic [3:0]  row1;
  wire  [3:0]  col1_w;
  logic [3:0]  code1;
  logic        strobe1;
  logic [15:0] entry1;
  logic [2:0]  dc1;
  logic        dr1, mk1, ov1;

  // 2 rows x 3 cols, SETTLE=2
  logic [5:0]  keys2 = '0;
  logic [1:0]  row2;
  wire  [2:0]  col2_w;
  logic [3:0]  code2;
  logic        strobe2;
  logic [15:0] entry2;
  logic [2:0]  dc2;
  logic        dr2, mk2, ov2;

  for (genvar i = 0; i < 4; i++) begin : g_pu1
    pullup (col1_w[i]);
  end
  for (genvar i = 0; i < 3; i++) begin : g_pu2
    pullup (col2_w[i]);
  end

  // Matrix model: a closed key pulls its row low only while its column is driven low.
  always_comb begin
    row1 = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys1[r*4 + c] && col1_w[c] == 1'b0) row1[r] = 1'b0;
  end
  always_comb begin
    row2 = '1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        if (keys2[r*3 + c] && col2_w[c] == 1'b0) row2[r] = 1'b0;
  end

  keypad_entry_scanner dut (
    .Clock(Clock), .Reset(Reset), .RowIn(row1), .ColOut(col1_w), .KeyRd(KeyRd),
    .key_code(code1), .key_strobe(strobe1), .entry(entry1), .digit_count(dc1),
    .data_ready(dr1), .multi_key(mk1), .overflow(ov1)
  );

  keypad_entry_scanner #(.ROWS(2), .COLS(3), .SETTLE(2)) dut2 (
    .Clock(Clock), .Reset(Reset2), .RowIn(row2), .ColOut(col2_w), .KeyRd(KeyRd2),
    .key_code(code2), .key_strobe(strobe2), .entry(entry2), .digit_count(dc2),
    .data_ready(dr2), .multi_key(mk2), .overflow(ov2)
  );

  int n1 = 0;
  always @(negedge Clock) if (strobe1) n1 = n1 + 1;

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance whole frames; returns just after the negedge following an EVAL edge.
  task automatic frames1(input int n);
    repeat (n*9) @(negedge Clock);
    #1;
  endtask

  task automatic pulse_keyrd();
    KeyRd = 1'b1;
    @(posedge Clock);
    #1;
    KeyRd = 1'b0;
  endtask

  logic [15:0] exp_entry;
  int n_before;

  initial begin
    @(negedge Clock);
    #1;
    check("rst_key_code", code1, 0);
    check("rst_strobe", strobe1, 0);
    check("rst_entry", entry1, 0);
    check("rst_count", dc1, 0);
    check("rst_ready", dr1, 0);
    check("rst_multi", mk1, 0);
    check("rst_ovf", ov1, 0);
    check("rst_col0", col1_w[0], 0);
    check("rst_col_hi", col1_w[3:1], 3'b111);
    check("rst2_col0", col2_w[0], 0);
    check("rst2_entry", entry2, 0);
    Reset = 1'b0;

    // first key needs a stable release, then two matching frames
    frames1(2);
    keys1[6] = 1'b1;
    frames1(1);
    check("press_no_early", strobe1, 0);
    frames1(1);
    check("press_strobe", strobe1, 1);
    check("press_code", code1, 6);
    check("press_entry", entry1, 16'h0006);
    check("press_count", dc1, 1);
    frames1(10);
    check("hold_no_repeat", n1, 1);

    // bounce: alternating frames never settle
    keys1 = '0;
    frames1(2);
    for (int i = 0; i < 8; i++) begin
      keys1[6] = (i % 2 == 0);
      frames1(1);
    end
    check("bounce_no_strobe", n1, 1);
    keys1[6] = 1'b1;
    frames1(2);
    check("bounce_then_stable", strobe1, 1);
    check("bounce_count", n1, 2);
    check("bounce_entry", entry1, 16'h0066);
    check("bounce_digits", dc1, 2);

    // asynchronous reset mid-frame discards the partial entry
    keys1 = '0;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("mid_rst_entry", entry1, 0);
    check("mid_rst_count", dc1, 0);
    check("mid_rst_code", code1, 0);
    check("mid_rst_col0", col1_w[0], 0);
    @(negedge Clock);
    #1;
    Reset = 1'b0;

    frames1(2);
    exp_entry = '0;
    for (int d = 1; d <= 4; d++) begin
      keys1[d] = 1'b1;
      frames1(2);
      exp_entry = (exp_entry << 4) | 16'(d);
      check("digit_strobe", strobe1, 1);
      check("digit_code", code1, d);
      check("digit_entry", entry1, exp_entry);
      check("digit_count", dc1, d);
      check("digit_ready", dr1, (d == 4));
      keys1 = '0;
      frames1(2);
    end
    check("entry_1234", entry1, 16'h1234);

    // key accepted while the entry is waiting: flagged, entry frozen
    keys1[5] = 1'b1;
    frames1(2);
    check("ovf_strobe", strobe1, 1);
    check("ovf_code", code1, 5);
    check("ovf_entry", entry1, 16'h1234);
    check("ovf_count", dc1, 4);
    check("ovf_flag", ov1, 1);
    check("ovf_ready", dr1, 1);
    keys1 = '0;
    pulse_keyrd();
    check("ack_ready", dr1, 0);
    check("ack_entry", entry1, 0);
    check("ack_count", dc1, 0);
    check("ack_ovf", ov1, 0);
    repeat (9) @(negedge Clock);
    #1;
    frames1(1);

    for (int d = 7; d <= 10; d++) begin
      keys1[d] = 1'b1;
      frames1(2);
      keys1 = '0;
      frames1(2);
    end
    check("entry_789a", entry1, 16'h789A);
    check("entry_789a_ready", dr1, 1);

    // KeyRd coincident with the accepting EVAL cycle
    keys1[11] = 1'b1;
    frames1(1);
    repeat (8) @(negedge Clock);
    KeyRd = 1'b1;
    @(negedge Clock);
    #1;
    KeyRd = 1'b0;
    check("sim_strobe", strobe1, 1);
    check("sim_code", code1, 11);
    check("sim_entry", entry1, 16'h000B);
    check("sim_count", dc1, 1);
    check("sim_ready", dr1, 0);
    check("sim_ovf", ov1, 0);

    keys1 = '0;
    pulse_keyrd();
    repeat (9) @(negedge Clock);
    #1;
    check("idle_ack_count", dc1, 1);
    check("idle_ack_entry", entry1, 16'h000B);

    // two keys closed together: flagged, never accepted
    frames1(1);
    n_before = n1;
    keys1[0]  = 1'b1;
    keys1[11] = 1'b1;
    frames1(3);
    check("multi_flag", mk1, 1);
    check("multi_no_strobe", n1, n_before);
    keys1 = '0;
    frames1(2);
    check("multi_clear", mk1, 0);
    keys1[12] = 1'b1;
    frames1(2);
    check("after_multi_strobe", strobe1, 1);
    check("after_multi_code", code1, 12);
    check("after_multi_entry", entry1, 16'h00BC);
    check("after_multi_count", dc1, 2);
    keys1 = '0;

    // 2x3 matrix, 10-cycle frame, key row1/col2 -> code 5
    Reset2 = 1'b0;
    repeat (20) @(negedge Clock);
    #1;
    keys2[5] = 1'b1;
    repeat (19) @(negedge Clock);
    #1;
    check("alt_no_early", strobe2, 0);
    @(negedge Clock);
    #1;
    check("alt_strobe", strobe2, 1);
    check("alt_code", code2, 5);
    check("alt_entry", entry2, 16'h0005);
    check("alt_count", dc2, 1);
    check("alt_multi", mk2, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/keypad_entry_scanner.md
# keypad_entry_scanner

Parametrised matrix-keypad scanner with multi-digit entry accumulation. It is the next generation of the team's 4x4 hex keypad scanner and generalises row/column count, settle time, debounce depth and entry length. It scans an open-drain column/row matrix and debounces each full-matrix frame. Accepted key codes are packed into an entry word, and the word is handed to the downstream consumer (MAC operand register / display path) through a data_ready/KeyRd handshake.

## Interface
Parameters:
- ROWS, 4, number of row inputs (>=1)
- COLS, 4, number of column outputs (>=2)
- DIGIT_W, 4, bits per key code; must be >= clog2(ROWS*COLS)
- DIGITS, 4, key codes per entry word (>=1)
- SETTLE, 1, extra cycles each column is driven before sampling (>=1)
- DEBOUNCE, 2, consecutive identical frames required (>=1, <=15)

Ports (one clock; reset is asynchronous and active-high):
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- RowIn  in  ROWS  row sense lines, pulled up, low = key closed in driven column
- ColOut  out  COLS  open-drain columns: active column driven 0, others high-Z
- KeyRd  in  1  consumer acknowledge of a complete entry
- key_code  out  DIGIT_W  code of last accepted key
- key_strobe  out  1  one-cycle pulse per accepted key
- entry  out  DIGITS*DIGIT_W  packed entry, first key in MS digit
- digit_count  out  clog2(DIGITS+1)  digits captured in current entry
- data_ready  out  1  entry complete, held until KeyRd
- multi_key  out  1  last frame saw more than one closed key
- overflow  out  1  sticky: key accepted while data_ready high

## Operation
- FSM states: SCAN, EVAL. Reset state SCAN with column index 0.
- SCAN: the column index c drives ColOut[c]=0. Each column slot lasts SETTLE+1 cycles. ~RowIn is sampled into frame bits [c*ROWS +: ROWS] on the last cycle of the slot. After column COLS-1 is sampled, the FSM goes to EVAL; otherwise c increments.
- EVAL (1 cycle): the frame is classified as NONE (0 closed), SINGLE(k) (exactly 1 closed), or MULTI (>1). k = row*COLS + col, zero-extended to DIGIT_W. The FSM then returns to SCAN with c=0. multi_key is updated here.
- Debounce: stable_cnt saturates at DEBOUNCE. It increments when the classification equals the previous frame's classification (including code k), and loads 1 otherwise.
- armed is set when NONE reaches stable_cnt==DEBOUNCE.
- A key is accepted when SINGLE(k) makes stable_cnt reach DEBOUNCE while armed is set. Acceptance clears armed. There is no auto-repeat; MULTI is never accepted.
- On accept with data_ready=0: entry shifts left by DIGIT_W with k in the LS digit, key_code=k, key_strobe=1, and digit_count increments. When digit_count reaches DIGITS, data_ready=1.
- On accept with data_ready=1: entry and digit_count stay frozen, key_code=k, key_strobe=1, overflow=1.
- KeyRd sampled high while data_ready=1: next cycle data_ready=0, digit_count=0, entry=0, overflow=0. KeyRd while data_ready=0 is ignored.
- Simultaneous accept and KeyRd (data_ready=1): the acknowledge wins first. The key then becomes digit 1 of a fresh entry: entry={0..,k}, digit_count=1, and overflow is not set.
- Scanning never stalls; it is independent of the handshake.

## Timing
- Frame period = COLS*(SETTLE+1)+1 cycles (9 at defaults).
- key_strobe, key_code, entry, digit_count and data_ready update on the clock edge ending EVAL, so they are visible the cycle after EVAL.
- Press-to-strobe: at least DEBOUNCE frames after the first frame that saw the key.
- Reset values: ColOut = {Z..Z,0} (column 0 driven), key_code=0, key_strobe=0, entry=0, digit_count=0, data_ready=0, multi_key=0, overflow=0. Internal state: armed=0, stable_cnt=0, previous class NONE.
- The board must therefore show a stable release before the first key is accepted.
- Reset asserted mid-frame or mid-entry: all state returns to reset values immediately (asynchronous). The partial entry is discarded.

## Test plan
- Defaults, idle for 2 frames, then hold row1/col2 closed: key_strobe pulses exactly once, at the end of frame 2 of the press, with key_code=6; entry=0x0006, digit_count=1. A 10-frame hold produces no further strobe.
- Bounce: toggle the key every frame for 8 frames -> no key_strobe. Then hold stable -> one strobe.
- Enter keys 1,2,3,4, each with a release between -> entry=0x1234 and data_ready=1 after the 4th strobe. Assert KeyRd for 1 cycle -> next cycle data_ready=0, entry=0, digit_count=0.
- With data_ready=1, press key 5 -> key_strobe=1 with key_code=5, entry stays 0x1234, overflow=1. Then KeyRd -> overflow=0.
- Hold row0/col0 and row2/col3 together -> multi_key=1 after EVAL, no strobe. Release and press a single key -> normal accept.
- Assert Reset for 1 cycle mid-frame after 2 digits -> all outputs at reset values, ColOut[0]=0. The next entry starts from digit 1. Repeat with ROWS=2, COLS=3, SETTLE=2: frame = 10 cycles, and key row1/col2 gives code 5.
